muldiv_unit: RTL

Iterative multiply/divide unit that gives the five-stage pipelined CPU the MIPS MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO group. It sits beside the EX-stage ALU and owns the HI/LO register pair. It accepts one operation at a time through a start/busy handshake. It reports a one-cycle done pulse so the hazard unit can stall MFHI/MFLO until the result exists. Operand width is parametrised; the CPU instantiates WIDTH=32.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
// Holds the MULT/MULTU/DIV/DIVU op codes and the FSM state encoding, and two
// small decode helpers. Control and the hazard unit import this package too.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'd0,
        OpMultu = 2'd1,
        OpDiv   = 2'd2,
        OpDivu  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } state_e;

    // Bit 1 of the op code selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// One operation at a time: start launches, busy covers the whole operation,
// done pulses for one cycle when HI/LO are committed (latency WIDTH+1).
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op, a, b   launch request, op code (muldiv_pkg::op_e), operands
//   flush             abort the in-flight operation; also blocks a launch
//   mthi, mtlo, wdata direct writes of HI/LO, honoured only when idle
//   busy, done        operation in flight / one-cycle commit pulse
//   hi, lo            architectural HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               state_q, state_d;
    logic                 div_q, div_d;     // latched op: divide vs multiply
    logic                 neg_q, neg_d;     // signed op and operand signs differ
    logic                 nega_q, nega_d;   // signed op and a < 0
    logic                 dz_q, dz_d;       // divide by zero
    logic [WIDTH-1:0]     a_q, a_d;         // |a|; shifted left during divide
    logic [WIDTH-1:0]     b_q, b_d;         // |b|; shifted right during multiply
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     acc_hi, acc_lo;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;

    assign neg_a  = op_is_signed(op) & a[WIDTH-1];
    assign neg_b  = op_is_signed(op) & b[WIDTH-1];
    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

    // Multiply: acc = {partial product, remaining multiplier-aligned bits};
    // the carry is kept and the whole thing shifts right one bit per cycle.
    assign mul_sum = {1'b0, acc_hi} + (b_q[0] ? {1'b0, a_q} : '0);

    // Divide: acc = {remainder, quotient}; the next dividend bit comes from
    // the MSB of a_q. A set MSB of the trial difference means "restore".
    assign div_trial = {acc_hi, a_q[WIDTH-1]} - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        dz_d    = dz_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d = StRun;
                    div_d   = op_is_div(op);
                    neg_d   = neg_a ^ neg_b;
                    nega_d  = neg_a;
                    dz_d    = (b == '0);
                    a_d     = neg_a ? -a : a;
                    b_d     = neg_b ? -b : b;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                end else if (!start) begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = StFix;
                    if (div_q) begin
                        a_d = {a_q[WIDTH-2:0], 1'b0};
                        if (div_trial[WIDTH]) begin
                            acc_d = {acc_hi[WIDTH-2:0], a_q[WIDTH-1], acc_lo[WIDTH-2:0], 1'b0};
                        end else begin
                            acc_d = {div_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        b_d   = {1'b0, b_q[WIDTH-1:1]};
                        acc_d = {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        // Zero divisor: restoring division already yields
                        // remainder |a|, so only the quotient needs forcing.
                        lo_d = dz_q ? '1 : (neg_q ? -acc_lo : acc_lo);
                        hi_d = nega_q ? -acc_hi : acc_hi;
                    end else begin
                        {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
